// File: rtl/gpio_in_capture_if.sv
// Register-port bundle for gpio_in_capture.
//   bus_stb   : one-cycle access strobe (master -> slave)
//   bus_we    : 1 = write, 0 = read (master -> slave)
//   bus_addr  : register select (master -> slave)
//   bus_wdata : write data (master -> slave)
//   bus_rdata : read data, zero unless bus_ack (slave -> master)
//   bus_ack   : one-cycle acknowledge (slave -> master)
interface gpio_in_capture_if #(
  parameter int unsigned WIDTH = 16
);
  logic             bus_stb;
  logic             bus_we;
  logic [1:0]       bus_addr;
  logic [WIDTH-1:0] bus_wdata;
  logic [WIDTH-1:0] bus_rdata;
  logic             bus_ack;

  modport master (
    output bus_stb, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_stb, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/gpio_in_capture.sv
// GPIO input capture: synchronise, debounce, detect edges into sticky
// W1C event bits, and raise a level interrupt while any event is pending.
//   clock, reset : system clock, synchronous active-high reset
//   pad_in       : raw pad inputs, asynchronous to clock
//   bus          : register port (0 DATA ro, 1 RISE_EN, 2 FALL_EN, 3 EVENT w1c)
//   irq          : high while any EVENT bit is set
module gpio_in_capture #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_in,
  gpio_in_capture_if.slave bus,
  output logic             irq
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RISE = 2'd1;
  localparam logic [1:0] ADDR_FALL = 2'd2;
  localparam logic [1:0] ADDR_EVT  = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q, last_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] evt_q, evt_d;
  logic             ack1_q, ack_q;
  logic [WIDTH-1:0] rd1_q, rd1_d, rdata_q;

  logic [WIDTH-1:0] set_c, clr_c, rmux_c;
  logic             wr_c;

  // Debounce, edge detection, register writes and read-data capture
  always_comb begin
    cnt_d     = '0;
    db_d      = db_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr_c     = '0;
    rmux_c    = '0;
    rd1_d     = '0;
    wr_c      = bus.bus_stb & bus.bus_we;

    // last_q is the previous sample of sync2_q; any difference restarts the count
    if (sync2_q == last_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
    if (cnt_d == CNT_MAX) begin
      db_d = sync2_q;
    end

    // Enables used here are the pre-write values, so writes apply from next cycle
    set_c = (db_d & ~db_q & rise_en_q) | (~db_d & db_q & fall_en_q);

    if (wr_c) begin
      unique case (bus.bus_addr)
        ADDR_RISE: rise_en_d = bus.bus_wdata;
        ADDR_FALL: fall_en_d = bus.bus_wdata;
        ADDR_EVT:  clr_c     = bus.bus_wdata;
        default:   ;
      endcase
    end

    // Set wins over a same-cycle clear
    evt_d = (evt_q & ~clr_c) | set_c;

    unique case (bus.bus_addr)
      ADDR_DATA: rmux_c = db_q;
      ADDR_RISE: rmux_c = rise_en_q;
      ADDR_FALL: rmux_c = fall_en_q;
      default:   rmux_c = evt_q;
    endcase
    if (bus.bus_stb && !bus.bus_we) begin
      rd1_d = rmux_c;
    end
  end

  // State registers; the ack travels through two stages so it appears one
  // cycle after the edge that commits the access
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      db_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      evt_q     <= '0;
      ack1_q    <= 1'b0;
      rd1_q     <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      sync1_q   <= pad_in;
      sync2_q   <= sync1_q;
      last_q    <= sync2_q;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      evt_q     <= evt_d;
      ack1_q    <= bus.bus_stb;
      rd1_q     <= rd1_d;
      ack_q     <= ack1_q;
      rdata_q   <= ack1_q ? rd1_q : '0;
    end
  end

  assign bus.bus_ack   = ack_q;
  assign bus.bus_rdata = rdata_q;
  assign irq           = |evt_q;

endmodule

// File: tb/tb_gpio_in_capture.sv
module tb_gpio_in_capture;
  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pad_in = '0;
  logic         irq;

  gpio_in_capture_if #(.WIDTH(W)) bus_if ();

  gpio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clock  (clock),
    .reset  (reset),
    .pad_in (pad_in),
    .bus    (bus_if.slave),
    .irq    (irq)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: debounced value = oldest-but-two sample when the last
  // D+1 synchronised samples agree; responses are scheduled by cycle number.
  int           cyc = 0;
  bit           started = 0;
  logic [W-1:0] hist[$];
  logic [W-1:0] m_db, m_rise, m_fall, m_evt;
  logic [W-1:0] pend[int];

  always @(posedge clock) begin
    logic [W-1:0] nd, set, clr, rd;
    bit stable;
    cyc++;
    if (reset) begin
      started = 1;
      m_db = '0; m_rise = '0; m_fall = '0; m_evt = '0;
      pend.delete();
      hist.delete();
      for (int i = 0; i < int'(D) + 3; i++) hist.push_back('0);
    end else if (started) begin
      hist.push_front(pad_in);
      void'(hist.pop_back());
      stable = 1;
      for (int i = 1; i <= int'(D); i++) if (hist[2+i] != hist[2]) stable = 0;
      nd  = stable ? hist[2] : m_db;
      set = (nd & ~m_db & m_rise) | (~nd & m_db & m_fall);
      clr = '0;
      if (bus_if.bus_stb) begin
        rd = '0;
        if (!bus_if.bus_we) begin
          case (bus_if.bus_addr)
            2'd0: rd = m_db;
            2'd1: rd = m_rise;
            2'd2: rd = m_fall;
            default: rd = m_evt;
          endcase
        end else begin
          case (bus_if.bus_addr)
            2'd1: m_rise = bus_if.bus_wdata;
            2'd2: m_fall = bus_if.bus_wdata;
            2'd3: clr = bus_if.bus_wdata;
            default: ;
          endcase
        end
        pend[cyc+1] = rd;
      end
      m_evt = (m_evt & ~clr) | set;
      m_db  = nd;
    end
  end

  always @(negedge clock) begin
    logic exp_ack;
    logic [W-1:0] exp_rd;
    if (started) begin
      exp_ack = pend.exists(cyc);
      exp_rd  = exp_ack ? pend[cyc] : '0;
      check("cyc_ack", 32'(bus_if.bus_ack), 32'(exp_ack));
      check("cyc_rdata", 32'(bus_if.bus_rdata), 32'(exp_rd));
      check("cyc_irq", 32'(irq), 32'(|m_evt));
      if (exp_ack) pend.delete(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
    bus_if.bus_stb = 1'b1; bus_if.bus_we = 1'b1;
    bus_if.bus_addr = a; bus_if.bus_wdata = d;
    @(negedge clock);
    bus_if.bus_stb = 1'b0; bus_if.bus_we = 1'b0;
    tick(1);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [W-1:0] d);
    bit got = 0;
    bus_if.bus_stb = 1'b1; bus_if.bus_we = 1'b0;
    bus_if.bus_addr = a; bus_if.bus_wdata = '0;
    @(negedge clock);
    bus_if.bus_stb = 1'b0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus_if.bus_ack) begin d = bus_if.bus_rdata; got = 1; break; end
    end
    check("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic rd_expect(input string name, input logic [1:0] a, input logic [W-1:0] exp);
    logic [W-1:0] d;
    bus_read(a, d);
    check(name, 32'(d), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus_if.bus_stb = 1'b0; bus_if.bus_we = 1'b0;
    bus_if.bus_addr = '0; bus_if.bus_wdata = '0;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Reset and idle
    check("irq_after_reset", 32'(irq), 32'd0);
    rd_expect("data_reset", 2'd0, 16'h0000);
    rd_expect("rise_reset", 2'd1, 16'h0000);
    rd_expect("fall_reset", 2'd2, 16'h0000);
    rd_expect("evt_reset",  2'd3, 16'h0000);

    // Latency and rise event
    bus_write(2'd1, 16'hFFFF);
    rd_expect("rise_rw", 2'd1, 16'hFFFF);
    pad_in = 16'h00F0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (irq) begin n = i; break; end
    end
    check("latency_edges", 32'(n - 1), 32'd6);
    rd_expect("data_f0", 2'd0, 16'h00F0);
    rd_expect("evt_f0",  2'd3, 16'h00F0);
    check("irq_f0", 32'(irq), 32'd1);

    // Glitch rejection, then a pulse just long enough
    bus_write(2'd3, 16'hFFFF);
    pad_in = 16'h00F1; tick(4); pad_in = 16'h00F0; tick(10);
    rd_expect("data_glitch", 2'd0, 16'h00F0);
    rd_expect("evt_glitch",  2'd3, 16'h0000);
    pad_in = 16'h00F1; tick(5); pad_in = 16'h00F0; tick(12);
    rd_expect("evt_pulse5", 2'd3, 16'h0001);

    // Fall and mask
    bus_write(2'd3, 16'hFFFF);
    bus_write(2'd2, 16'h000F);
    bus_write(2'd1, 16'h0000);
    pad_in = 16'h0F0F; tick(10);
    pad_in = 16'h0000; tick(10);
    rd_expect("evt_fall", 2'd3, 16'h000F);

    // W1C and set/clear collision
    bus_write(2'd3, 16'hFFFF);
    bus_write(2'd1, 16'h0003);
    bus_write(2'd2, 16'h0000);
    pad_in = 16'h0003; tick(10);
    rd_expect("evt_03", 2'd3, 16'h0003);
    bus_write(2'd3, 16'h0001);
    rd_expect("evt_w1c", 2'd3, 16'h0002);
    check("irq_w1c", 32'(irq), 32'd1);
    bus_write(2'd3, 16'h0002);
    pad_in = 16'h0001; tick(10);
    pad_in = 16'h0003; tick(6);
    bus_write(2'd3, 16'h0002);
    rd_expect("evt_collide", 2'd3, 16'h0002);
    bus_write(2'd3, 16'hFFFF);
    tick(1);
    check("irq_cleared", 32'(irq), 32'd0);

    // Reset mid-operation, including a pending ack
    bus_write(2'd1, 16'h00FF);
    pad_in = 16'h0000; tick(10);
    bus_write(2'd3, 16'hFFFF);
    pad_in = 16'h00FF; tick(10);
    rd_expect("evt_ff", 2'd3, 16'h00FF);
    pad_in = 16'hFFFF; tick(3);
    bus_if.bus_stb = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = 2'd3;
    @(negedge clock);
    bus_if.bus_stb = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("ack_dropped", 32'(bus_if.bus_ack), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    rd_expect("data_post_reset", 2'd0, 16'h0000);
    tick(15);
    rd_expect("rise_post_reset", 2'd1, 16'h0000);
    rd_expect("fall_post_reset", 2'd2, 16'h0000);
    rd_expect("evt_post_reset",  2'd3, 16'h0000);
    rd_expect("data_settled",    2'd0, 16'hFFFF);
    check("irq_post_reset", 32'(irq), 32'd0);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
